// File: rtl/hz_pkg.sv
// Shared types for the pipeline hazard controller: forwarding codes, FSM states
// and the scoreboard entry that tracks in-flight register writers.
package hz_pkg;

    // Widest register index a scoreboard entry can carry; REGW must not exceed it.
    localparam int REGW_MAX = 16;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB  = 2'b11
    } fwd_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_HOLD
    } state_e;

    typedef struct packed {
        logic                valid;
        logic                wreg;
        logic                m2reg;
        logic [REGW_MAX-1:0] dest;
    } sb_entry_t;

    // A load still in EX cannot forward yet, so it yields the regfile code while ldu stalls.
    function automatic fwd_e fwd_sel(input logic ex_hit, input logic ex_load,
                                     input logic mem_hit, input logic wb_hit);
        if (ex_hit)       return ex_load ? FWD_RF : FWD_EX;
        else if (mem_hit) return FWD_MEM;
        else if (wb_hit)  return FWD_WB;
        else              return FWD_RF;
    endfunction

endpackage

// File: rtl/hz_match.sv
// Compares one scoreboard entry against one ID source register index.
module hz_match
    import hz_pkg::*;
(
    input  logic                valid,
    input  logic                wreg,
    input  logic [REGW_MAX-1:0] dest,
    input  logic [REGW_MAX-1:0] src,
    input  logic                use_src,
    output logic                match
);

    // r0 is hard-wired to zero, so a write to it never produces a dependency.
    assign match = valid && wreg && (dest != '0) && (dest == src) && use_src;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, external hold and forwarding control for a 5-stage pipeline,
// driven by a three-entry scoreboard shadowing the EX, MEM and WB stages.
module pipe_hazard_ctrl
    import hz_pkg::*;
#(
    parameter int REGW = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic [REGW-1:0] id_dest,
    input  logic            id_branch_taken,
    input  logic            ext_hold,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_bubble,
    output logic            if_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic [CNTW-1:0] stall_cnt
);

    state_e              state, state_next;
    sb_entry_t           sb [3];          // 0 = EX, 1 = MEM, 2 = WB
    sb_entry_t           id_entry;
    logic [REGW_MAX-1:0] src_a, src_b;
    logic [2:0]          hit_a, hit_b;
    logic                ldu, held;

    assign src_a    = REGW_MAX'(id_rs);
    assign src_b    = REGW_MAX'(id_rt);
    assign id_entry = '{valid: id_valid, wreg: id_wreg, m2reg: id_m2reg,
                        dest: REGW_MAX'(id_dest)};

    for (genvar s = 0; s < 3; s++) begin : g_match
        hz_match u_match_a (
            .valid(sb[s].valid), .wreg(sb[s].wreg), .dest(sb[s].dest),
            .src(src_a), .use_src(id_use_rs), .match(hit_a[s])
        );
        hz_match u_match_b (
            .valid(sb[s].valid), .wreg(sb[s].wreg), .dest(sb[s].dest),
            .src(src_b), .use_src(id_use_rt), .match(hit_b[s])
        );
    end

    assign ldu  = sb[0].m2reg && (hit_a[0] || hit_b[0]);
    assign held = ext_hold || (state == ST_HOLD);

    // NOTE: the scoreboard is a handful of flops rather than a RAM, so it is
    // cleared on reset; non-blocking updates let WB<=MEM<=EX shift in one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
            for (int i = 0; i < 3; i++) sb[i] <= '0;
        end else begin
            state <= state_next;
            if (!held) begin
                sb[2] <= sb[1];
                sb[1] <= sb[0];
                sb[0] <= (id_valid && !ldu) ? id_entry : '0;
            end
            // The stall cycle itself happened even if a hold lands on it.
            if (state == ST_LDSTALL && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next  = state;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b0;
        case (state)
            ST_RUN: begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                if (ext_hold) state_next = ST_HOLD;
                else if (ldu) state_next = ST_LDSTALL;
            end
            ST_LDSTALL: begin
                idex_bubble = 1'b1;
                state_next  = ext_hold ? ST_HOLD : ST_RUN;
            end
            ST_HOLD: begin
                if (!ext_hold) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    assign if_flush = id_branch_taken && id_valid && (state == ST_RUN) && !ldu
                      && !ext_hold && !rst;

    assign fwd_a = rst ? FWD_RF : fwd_sel(hit_a[0], sb[0].m2reg, hit_a[1], hit_a[2]);
    assign fwd_b = rst ? FWD_RF : fwd_sel(hit_b[0], sb[0].m2reg, hit_b[1], hit_b[2]);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed cycle-by-cycle bench for pipe_hazard_ctrl; a second instance with a
// 2-bit counter runs the same stimulus to exercise stall-counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, id_branch_taken;
    logic [4:0] id_rs, id_rt, id_dest;
    logic       ext_hold;

    logic        pc_en, ifid_en, idex_bubble, if_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_ifid_en, s_idex_bubble, s_if_flush;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_stall_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_dest(id_dest), .id_branch_taken(id_branch_taken),
        .ext_hold(ext_hold), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_bubble(idex_bubble), .if_flush(if_flush), .fwd_a(fwd_a),
        .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.REGW(5), .CNTW(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_dest(id_dest), .id_branch_taken(id_branch_taken),
        .ext_hold(ext_hold), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
        .idex_bubble(s_idex_bubble), .if_flush(s_if_flush), .fwd_a(s_fwd_a),
        .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    endtask

    task automatic id_set(input logic v, input int rs, input logic urs, input int rt,
                          input logic urt, input logic w, input logic m, input int d,
                          input logic br);
        id_valid        = v;
        id_rs           = 5'(rs);
        id_use_rs       = urs;
        id_rt           = 5'(rt);
        id_use_rt       = urt;
        id_wreg         = w;
        id_m2reg        = m;
        id_dest         = 5'(d);
        id_branch_taken = br;
    endtask

    // Checks the combinational outputs mid-cycle, then advances one clock.
    task automatic cycle_check(input string tag, input logic pc, input logic bub,
                               input logic fl, input logic [1:0] fa,
                               input logic [1:0] fb, input int cnt);
        int sat;
        #2;
        sat = (cnt > 3) ? 3 : cnt;
        check({tag, ".pc_en"},       32'(pc_en),       32'(pc));
        check({tag, ".ifid_en"},     32'(ifid_en),     32'(pc));
        check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(bub));
        check({tag, ".if_flush"},    32'(if_flush),    32'(fl));
        check({tag, ".fwd_a"},       32'(fwd_a),       32'(fa));
        check({tag, ".fwd_b"},       32'(fwd_b),       32'(fb));
        check({tag, ".stall_cnt"},   32'(stall_cnt),   32'(cnt));
        check({tag, ".sat_cnt"},     32'(s_stall_cnt), 32'(sat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        ext_hold = 1'b0;
        id_set(1, 1, 1, 2, 1, 1, 0, 3, 1);
        @(posedge clk);
        #1;
        cycle_check("reset", 0, 1, 0, 2'b00, 2'b00, 0);
        rst = 1'b0;

        // Forwarding distance and priority: add r3 then dependents.
        id_set(1, 1, 1, 2, 1, 1, 0, 3, 0); cycle_check("c01_add_r3",    1, 0, 0, 2'b00, 2'b00, 0);
        id_set(1, 3, 1, 2, 1, 1, 0, 4, 0); cycle_check("c02_ex_fwd",    1, 0, 0, 2'b01, 2'b00, 0);
        id_set(1, 8, 1, 3, 1, 1, 0, 6, 0); cycle_check("c03_mem_fwd",   1, 0, 0, 2'b00, 2'b10, 0);
        id_set(1, 3, 1, 4, 1, 0, 0, 0, 0); cycle_check("c04_wb_fwd",    1, 0, 0, 2'b11, 2'b10, 0);
        id_set(1, 3, 1, 6, 1, 1, 0, 6, 0); cycle_check("c05_retired",   1, 0, 0, 2'b00, 2'b10, 0);
        id_set(1, 6, 1, 4, 1, 1, 0, 6, 0); cycle_check("c06_ex_over_wb",1, 0, 0, 2'b01, 2'b00, 0);
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle_check("c07_idle",      1, 0, 0, 2'b00, 2'b00, 0);
        id_set(1, 6, 1, 6, 0, 0, 0, 0, 0); cycle_check("c08_mem_over_wb",1,0, 0, 2'b10, 2'b00, 0);
        id_set(1, 6, 1, 0, 1, 0, 0, 0, 0); cycle_check("c09_wb_only",   1, 0, 0, 2'b11, 2'b00, 0);

        // Writes to r0 never forward and never stall.
        id_set(1, 1, 1, 2, 1, 1, 0, 0, 0); cycle_check("c10_wr_r0",     1, 0, 0, 2'b00, 2'b00, 0);
        id_set(1, 0, 1, 0, 0, 1, 1, 0, 0); cycle_check("c11_lw_r0",     1, 0, 0, 2'b00, 2'b00, 0);
        id_set(1, 0, 1, 0, 1, 0, 0, 0, 0); cycle_check("c12_rd_r0",     1, 0, 0, 2'b00, 2'b00, 0);
        id_set(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle_check("c13_no_stall",  1, 0, 0, 2'b00, 2'b00, 0);

        // Load-use: lw r5 then a reader of rt=r5.
        id_set(1, 1, 1, 0, 0, 1, 1, 5, 0); cycle_check("c14_lw_r5",     1, 0, 0, 2'b00, 2'b00, 0);
        id_set(1, 9, 1, 5, 1, 1, 0, 7, 0); cycle_check("c15_ldu",       1, 0, 0, 2'b00, 2'b00, 0);
        cycle_check("c16_ldstall", 0, 1, 0, 2'b00, 2'b10, 0);
        id_set(1, 7, 1, 5, 1, 0, 0, 0, 0); cycle_check("c17_after",     1, 0, 0, 2'b01, 2'b11, 1);

        // Taken branch blocked by a load-use stall flushes only once unstalled.
        id_set(1, 1, 1, 0, 0, 1, 1, 8, 0); cycle_check("c18_lw_r8",     1, 0, 0, 2'b00, 2'b00, 1);
        id_set(1, 8, 1, 7, 1, 0, 0, 0, 1); cycle_check("c19_br_ldu",    1, 0, 0, 2'b00, 2'b11, 1);
        cycle_check("c20_br_stall", 0, 1, 0, 2'b10, 2'b00, 1);
        cycle_check("c21_br_flush", 1, 0, 1, 2'b11, 2'b00, 2);
        id_set(0, 8, 1, 0, 0, 0, 0, 0, 1); cycle_check("c22_flushed",   1, 0, 0, 2'b00, 2'b00, 2);

        // External hold landing on the stall cycle.
        id_set(1, 1, 1, 0, 0, 1, 1, 10, 0); cycle_check("c23_lw_r10",   1, 0, 0, 2'b00, 2'b00, 2);
        id_set(1, 10, 1, 0, 0, 0, 0, 0, 0); cycle_check("c24_ldu",      1, 0, 0, 2'b00, 2'b00, 2);
        ext_hold = 1'b1;                    cycle_check("c25_stall_hold",0, 1, 0, 2'b10, 2'b00, 2);
        cycle_check("c26_hold1", 0, 0, 0, 2'b10, 2'b00, 3);
        cycle_check("c27_hold2", 0, 0, 0, 2'b10, 2'b00, 3);
        ext_hold = 1'b0;                    cycle_check("c28_hold3",    0, 0, 0, 2'b10, 2'b00, 3);
        cycle_check("c29_run", 1, 0, 0, 2'b10, 2'b00, 3);

        // Hold wins over ldu; ldu re-evaluated from the frozen scoreboard.
        id_set(1, 1, 1, 0, 0, 1, 1, 11, 0); cycle_check("c30_lw_r11",   1, 0, 0, 2'b00, 2'b00, 3);
        id_set(1, 11, 1, 0, 0, 0, 0, 0, 0);
        ext_hold = 1'b1;                    cycle_check("c31_hold_ldu", 1, 0, 0, 2'b00, 2'b00, 3);
        ext_hold = 1'b0;                    cycle_check("c32_hold_exit",0, 0, 0, 2'b00, 2'b00, 3);
        cycle_check("c33_reldu",   1, 0, 0, 2'b00, 2'b00, 3);
        cycle_check("c34_ldstall", 0, 1, 0, 2'b10, 2'b00, 3);
        ext_hold = 1'b1;                    cycle_check("c35_sat",      1, 0, 0, 2'b11, 2'b00, 4);

        // Reset in the middle of a hold abandons everything.
        id_set(1, 11, 1, 0, 0, 0, 0, 0, 1);
        rst = 1'b1;                         cycle_check("c36_rst_hold", 0, 1, 0, 2'b00, 2'b00, 0);
        rst = 1'b0;
        ext_hold = 1'b0;
        id_set(1, 11, 1, 11, 1, 0, 0, 0, 0); cycle_check("c37_post_rst",1, 0, 0, 2'b00, 2'b00, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
